// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, MSB first, single-byte output buffer
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxpulse,
    input  logic       i_rxd,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta_q, rxs_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          byte_done, stop_bad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (i_rxpulse) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    // Half a bit in: a high line here means a glitch, not a start bit.
                    if (cnt_q == HALF_LAST) begin
                        if (rxs_q) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        shift_d = {shift_q[6:0], rxs_q};
                        cnt_d   = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                        byte_done = rxs_q;
                        stop_bad  = !rxs_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A consume in the same cycle frees the buffer, so a completing byte is never dropped then.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = stop_bad;
        ovr_d   = 1'b0;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_rxd;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
module tb_uart_rx;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxpulse = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr;

    int checks = 0;
    int failures = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_hs = 0;
    int f0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_rxpulse(rxpulse), .i_rxd(rxd), .i_ready(ready),
        .o_data(data), .o_valid(valid), .o_frame_err(ferr), .o_overrun(ovr)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 rxpulse = 1'b1;
            @(posedge clk);
            #1 rxpulse = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input logic [7:0] b);
        rxd = 1'b0;
        wait_clks(BIT);
        for (int i = 7; i >= 0; i--) begin
            rxd = b[i];
            wait_clks(BIT);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        rxd = stop;
        wait_clks(BIT);
        rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
            if (ferr || ovr) check("pulse_exclusive", 32'(ferr && ovr), 32'h0);
            if (valid && ready) begin
                n_hs++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_byte observed=0x%0h expected=none", data);
                end
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check("scoreboard_byte", 32'(data), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        wait_clks(5);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(ferr), 32'h0);
        check("rst_ovr", 32'(ovr), 32'h0);
        rst = 1'b0;
        wait_clks(20);

        // 0xA5: output appears only after the stop-bit centre
        ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_head(8'hA5);
        rxd = 1'b1;
        wait_clks(20);
        check("a5_valid_before_stop_sample", 32'(valid), 32'h0);
        wait_clks(44);
        check("a5_valid", 32'(valid), 32'h1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_no_ferr", 32'(n_ferr), 32'h0);
        check("a5_no_ovr", 32'(n_ovr), 32'h0);
        ready = 1'b1;
        wait_clks(2);
        check("a5_valid_drop", 32'(valid), 32'h0);

        // false start
        rxd = 1'b0;
        wait_clks(16);
        rxd = 1'b1;
        wait_clks(200);
        check("false_start_valid", 32'(valid), 32'h0);
        check("false_start_ferr", 32'(n_ferr), 32'h0);

        // framing error
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        wait_clks(100);
        check("ferr_count", 32'(n_ferr - f0), 32'h1);
        check("ferr_valid", 32'(valid), 32'h0);

        // overrun
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clks(20);
        check("ovr_data_held", 32'(data), 32'h11);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_count", 32'(n_ovr), 32'h1);
        ready = 1'b1;
        wait_clks(2);
        check("ovr_valid_drop", 32'(valid), 32'h0);

        // reset after 3 data bits
        ready = 1'b0;
        rxd = 1'b0;
        wait_clks(BIT);
        rxd = 1'b0;
        wait_clks(BIT);
        rxd = 1'b1;
        wait_clks(BIT);
        rxd = 1'b0;
        wait_clks(BIT / 2);
        #3 rst = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_ferr", 32'(ferr), 32'h0);
        check("midrst_ovr", 32'(ovr), 32'h0);
        wait_clks(10);
        rxd = 1'b1;
        rst = 1'b0;
        f0 = n_ferr;
        wait_clks(100);
        check("midrst_no_valid", 32'(valid), 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clks(10);
        check("5a_data", 32'(data), 32'h5A);
        check("5a_valid", 32'(valid), 32'h1);
        check("midrst_no_ferr", 32'(n_ferr - f0), 32'h0);
        ready = 1'b1;
        wait_clks(3);

        // back-to-back
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_clks(100);
        check("total_handshakes", 32'(n_hs), 32'd6);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("total_ovr", 32'(n_ovr), 32'h1);
        check("total_ferr", 32'(n_ferr), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
